// File: rtl/midi_voice_alloc.sv
// MIDI byte parser feeding a scanning voice-slot allocator (note on/off, aftertouch, pitch bend).
// Optional feature: define VOICE_STEAL_EN to steal a slot when a note-on finds none free.
module midi_voice_alloc #(
   parameter int unsigned NVOICE = 16
) (
   input  logic       clk96,
   input  logic       rst,
   input  logic [7:0] midi_byte,
   input  logic       midi_byte_valid,
   input  logic [7:0] voice_free_addr,
   input  logic       voice_free_valid,
   output logic       note_pressed,
   output logic       note_released,
   output logic       note_keypress,
   output logic       pitch_wheel,
   output logic [6:0] note,
   output logic [6:0] velocity,
   output logic [3:0] channel,
   output logic [7:0] addr,
   output logic       overflow
);
   localparam int unsigned IW = $clog2(NVOICE + 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT} fsm_e;
   typedef enum logic [1:0] {V_FREE, V_HELD, V_REL} slot_e;
   typedef enum logic [1:0] {M_ON, M_OFF, M_AT, M_BEND} kind_e;
   typedef struct packed {
      kind_e      kind;
      logic [3:0] ch;
      logic [6:0] key;
      logic [6:0] vel;
   } msg_t;

   logic [7:0] status_q, status_d;
   logic       have_d1_q, have_d1_d;
   logic [6:0] d1_q, d1_d;
   logic       msg_vld;
   msg_t       msg;
   logic       two_byte, handled;

   // Byte parser with running status; realtime bytes pass through untouched.
   always_comb begin
      status_d  = status_q;
      have_d1_d = have_d1_q;
      d1_d      = d1_q;
      msg_vld   = 1'b0;
      msg       = '0;
      two_byte  = (status_q[6:4] != 3'b100) && (status_q[6:4] != 3'b101);
      handled   = (status_q[6:4] == 3'b000) || (status_q[6:4] == 3'b001) ||
                  (status_q[6:4] == 3'b010) || (status_q[6:4] == 3'b110);
      if (midi_byte_valid) begin
         if (midi_byte[7]) begin
            if (midi_byte[7:3] != 5'b11111) begin
               status_d  = (midi_byte[7:4] == 4'hF) ? 8'h00 : midi_byte;
               have_d1_d = 1'b0;
            end
         end else if (status_q[7]) begin
            if (two_byte && !have_d1_q) begin
               have_d1_d = 1'b1;
               d1_d      = midi_byte[6:0];
            end else begin
               have_d1_d = 1'b0;
               msg_vld   = handled;
               msg.ch    = status_q[3:0];
               msg.key   = d1_q;
               msg.vel   = midi_byte[6:0];
               case (status_q[6:4])
                  3'b000:  msg.kind = M_OFF;
                  3'b001:  msg.kind = (midi_byte[6:0] == 7'd0) ? M_OFF : M_ON;
                  3'b010:  msg.kind = M_AT;
                  default: begin
                     msg.kind = M_BEND;
                     msg.key  = midi_byte[6:0];
                     msg.vel  = d1_q;
                  end
               endcase
            end
         end
      end
   end

   slot_e      slot_st_q  [NVOICE];
   slot_e      slot_st_d  [NVOICE];
   logic [3:0] slot_ch_q  [NVOICE];
   logic [3:0] slot_ch_d  [NVOICE];
   logic [6:0] slot_key_q [NVOICE];
   logic [6:0] slot_key_d [NVOICE];

   fsm_e          state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   msg_t          cur_q, cur_d, pend_q, pend_d, start_msg;
   logic          pend_vld_q, pend_vld_d, start_en;
   logic          note_pressed_q, note_pressed_d, note_released_q, note_released_d;
   logic          note_keypress_q, note_keypress_d, pitch_wheel_q, pitch_wheel_d;
   logic [6:0]    note_q, note_d, velocity_q, velocity_d;
   logic [3:0]    channel_q, channel_d;
   logic [7:0]    addr_q, addr_d;
   logic          overflow_q, overflow_d;
`ifdef VOICE_STEAL_EN
   logic [IW-1:0] steal_q, steal_d;
`endif

   slot_e         sel_st;
   logic [3:0]    sel_ch;
   logic [6:0]    sel_key;
   logic          hit;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   slot_e         wr_st;

   // Entry under the scan pointer and whether it satisfies the current message.
   always_comb begin
      sel_st  = V_FREE;
      sel_ch  = '0;
      sel_key = '0;
      for (int unsigned i = 0; i < NVOICE; i++) begin
         if (idx_q == IW'(i)) begin
            sel_st  = slot_st_q[i];
            sel_ch  = slot_ch_q[i];
            sel_key = slot_key_q[i];
         end
      end
      if (cur_q.kind == M_ON) hit = (sel_st == V_FREE);
      else hit = (sel_st == V_HELD) && (sel_ch == cur_q.ch) && (sel_key == cur_q.key);
   end

   // Allocation FSM, pending register and event outputs.
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      cur_d           = cur_q;
      pend_d          = pend_q;
      pend_vld_d      = pend_vld_q;
      note_pressed_d  = 1'b0;
      note_released_d = 1'b0;
      note_keypress_d = 1'b0;
      pitch_wheel_d   = 1'b0;
      note_d          = note_q;
      velocity_d      = velocity_q;
      channel_d       = channel_q;
      addr_d          = addr_q;
      overflow_d      = overflow_q;
      start_en        = 1'b0;
      start_msg       = msg;
      wr_en           = 1'b0;
      wr_idx          = idx_q;
      wr_st           = V_HELD;
`ifdef VOICE_STEAL_EN
      steal_d         = steal_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (pend_vld_q) begin
               start_en   = 1'b1;
               start_msg  = pend_q;
               pend_vld_d = msg_vld;
               pend_d     = msg;
            end else if (msg_vld) begin
               start_en = 1'b1;
            end
         end
         S_SCAN: begin
`ifdef VOICE_STEAL_EN
            if (idx_q == IW'(NVOICE)) begin
               note_pressed_d = 1'b1;
               addr_d         = 8'(steal_q);
               note_d         = cur_q.key;
               velocity_d     = cur_q.vel;
               channel_d      = cur_q.ch;
               wr_en          = 1'b1;
               wr_idx         = steal_q;
               steal_d        = (steal_q == IW'(NVOICE - 1)) ? '0 : steal_q + IW'(1);
               state_d        = S_EMIT;
            end else
`endif
            if (hit) begin
               addr_d     = 8'(idx_q);
               note_d     = cur_q.key;
               velocity_d = cur_q.vel;
               channel_d  = cur_q.ch;
               state_d    = S_EMIT;
               case (cur_q.kind)
                  M_ON: begin
                     note_pressed_d = 1'b1;
                     wr_en          = 1'b1;
                  end
                  M_OFF: begin
                     note_released_d = 1'b1;
                     wr_en           = 1'b1;
                     wr_st           = V_REL;
                  end
                  default: note_keypress_d = 1'b1;
               endcase
            end else if (idx_q == IW'(NVOICE - 1)) begin
`ifdef VOICE_STEAL_EN
               if (cur_q.kind == M_ON) idx_d = idx_q + IW'(1);
               else state_d = S_IDLE;
`else
               state_d = S_IDLE;
`endif
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_q != S_IDLE && msg_vld) begin
         if (pend_vld_q) begin
            overflow_d = 1'b1;
         end else begin
            pend_vld_d = 1'b1;
            pend_d     = msg;
         end
      end
      if (start_en) begin
         cur_d = start_msg;
         idx_d = '0;
         if (start_msg.kind == M_BEND) begin
            pitch_wheel_d = 1'b1;
            note_d        = start_msg.key;
            channel_d     = start_msg.ch;
            state_d       = S_EMIT;
         end else begin
            state_d = S_SCAN;
         end
      end
   end

   // Slot table: external frees first, so an allocation to the same entry overrides them.
   always_comb begin
      for (int unsigned i = 0; i < NVOICE; i++) begin
         slot_st_d[i]  = slot_st_q[i];
         slot_ch_d[i]  = slot_ch_q[i];
         slot_key_d[i] = slot_key_q[i];
         if (voice_free_valid && voice_free_addr == 8'(i)) slot_st_d[i] = V_FREE;
         if (wr_en && wr_idx == IW'(i)) begin
            slot_st_d[i]  = wr_st;
            slot_ch_d[i]  = cur_q.ch;
            slot_key_d[i] = cur_q.key;
         end
      end
   end

   always_ff @(posedge clk96) begin
      if (rst) begin
         status_q        <= '0;
         have_d1_q       <= 1'b0;
         d1_q            <= '0;
         state_q         <= S_IDLE;
         idx_q           <= '0;
         cur_q           <= '0;
         pend_q          <= '0;
         pend_vld_q      <= 1'b0;
         note_pressed_q  <= 1'b0;
         note_released_q <= 1'b0;
         note_keypress_q <= 1'b0;
         pitch_wheel_q   <= 1'b0;
         note_q          <= '0;
         velocity_q      <= '0;
         channel_q       <= '0;
         addr_q          <= '0;
         overflow_q      <= 1'b0;
`ifdef VOICE_STEAL_EN
         steal_q         <= '0;
`endif
         for (int unsigned i = 0; i < NVOICE; i++) begin
            slot_st_q[i]  <= V_FREE;
            slot_ch_q[i]  <= '0;
            slot_key_q[i] <= '0;
         end
      end else begin
         status_q        <= status_d;
         have_d1_q       <= have_d1_d;
         d1_q            <= d1_d;
         state_q         <= state_d;
         idx_q           <= idx_d;
         cur_q           <= cur_d;
         pend_q          <= pend_d;
         pend_vld_q      <= pend_vld_d;
         note_pressed_q  <= note_pressed_d;
         note_released_q <= note_released_d;
         note_keypress_q <= note_keypress_d;
         pitch_wheel_q   <= pitch_wheel_d;
         note_q          <= note_d;
         velocity_q      <= velocity_d;
         channel_q       <= channel_d;
         addr_q          <= addr_d;
         overflow_q      <= overflow_d;
`ifdef VOICE_STEAL_EN
         steal_q         <= steal_d;
`endif
         slot_st_q       <= slot_st_d;
         slot_ch_q       <= slot_ch_d;
         slot_key_q      <= slot_key_d;
      end
   end

   assign note_pressed  = note_pressed_q;
   assign note_released = note_released_q;
   assign note_keypress = note_keypress_q;
   assign pitch_wheel   = pitch_wheel_q;
   assign note          = note_q;
   assign velocity      = velocity_q;
   assign channel       = channel_q;
   assign addr          = addr_q;
   assign overflow      = overflow_q;
endmodule

// File: tb/tb_midi_voice_alloc.sv
// Bench for midi_voice_alloc: directed scenarios plus random byte/free traffic against a timing-level model.
module tb_midi_voice_alloc;
   localparam int NV = 4;
`ifdef VOICE_STEAL_EN
   localparam bit STEAL = 1'b1;
`else
   localparam bit STEAL = 1'b0;
`endif
   localparam int FREE = 0, HELD = 1, REL = 2;
   localparam int ON = 0, OFF = 1, AT = 2, BEND = 3;
   localparam int EV_PRESS = 1, EV_REL = 2, EV_KP = 3, EV_PW = 4;

   logic       clk96 = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] midi_byte = '0;
   logic       midi_byte_valid = 1'b0;
   logic [7:0] voice_free_addr = '0;
   logic       voice_free_valid = 1'b0;
   logic       note_pressed, note_released, note_keypress, pitch_wheel, overflow;
   logic [6:0] note, velocity;
   logic [3:0] channel;
   logic [7:0] addr;

   always #5 clk96 = ~clk96;

   midi_voice_alloc #(.NVOICE(NV)) dut (
      .clk96(clk96), .rst(rst), .midi_byte(midi_byte), .midi_byte_valid(midi_byte_valid),
      .voice_free_addr(voice_free_addr), .voice_free_valid(voice_free_valid),
      .note_pressed(note_pressed), .note_released(note_released), .note_keypress(note_keypress),
      .pitch_wheel(pitch_wheel), .note(note), .velocity(velocity), .channel(channel),
      .addr(addr), .overflow(overflow)
   );

   typedef struct {int kind; int ch; int key; int vel;} mmsg_t;
   typedef struct {int cyc; int kind; int addr; int note; int vel; int ch;} ev_t;

   int    cyc = 0;
   int    n_chk = 0, n_fail = 0;
   ev_t   log_q[$];

   // Model state: FSM is idle in cycle c when no scan is running and c > busy_until.
   int    st[NV], chs[NV], keys[NV];
   int    rs = -1;
   int    dq[$];
   bit    scanning = 1'b0;
   int    t0 = 0, busy_until = -1, steal = 0;
   mmsg_t cur, pend;
   bit    pend_v = 1'b0;
   bit    e_pr, e_rl, e_kp, e_pw, e_ovf;
   int    e_note, e_vel, e_ch, e_addr;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic start_msg(input mmsg_t m);
      if (m.kind == BEND) begin
         e_pw = 1'b1; e_note = m.key; e_ch = m.ch;
         busy_until = cyc + 1;
      end else begin
         cur = m; scanning = 1'b1; t0 = cyc;
      end
   endtask

   // Predict the outputs of cycle cyc+1 from the inputs applied in cycle cyc.
   task automatic model_step(input bit r, input int b, input bit bv, input int fa, input bit fv);
      mmsg_t m;
      bit    got, idle, wr, hit;
      int    i, hi, wi, wst;
      if (r) begin
         for (int k = 0; k < NV; k++) begin st[k] = FREE; chs[k] = 0; keys[k] = 0; end
         rs = -1; dq.delete(); scanning = 1'b0; busy_until = -1; pend_v = 1'b0; steal = 0;
         e_pr = 0; e_rl = 0; e_kp = 0; e_pw = 0; e_ovf = 0;
         e_note = 0; e_vel = 0; e_ch = 0; e_addr = 0;
         return;
      end
      e_pr = 0; e_rl = 0; e_kp = 0; e_pw = 0;
      got = 0; wr = 0; wi = 0; wst = HELD;
      m = '{kind: ON, ch: 0, key: 0, vel: 0};
      if (bv) begin
         if (b >= 'h80) begin
            if (b < 'hF8) begin
               rs = (b >= 'hF0) ? -1 : b;
               dq.delete();
            end
         end else if (rs >= 0) begin
            hi = rs >> 4;
            dq.push_back(b);
            if (dq.size() == ((hi == 12 || hi == 13) ? 1 : 2)) begin
               m.ch = rs & 15;
               if (hi == 14) begin
                  m.kind = BEND; m.key = dq[1]; got = 1;
               end else if (hi >= 8 && hi <= 10) begin
                  m.key = dq[0]; m.vel = dq[1]; got = 1;
                  m.kind = (hi == 10) ? AT : ((hi == 9 && dq[1] != 0) ? ON : OFF);
               end
               dq.delete();
            end
         end
      end
      idle = !scanning && cyc > busy_until;
      if (scanning) begin
         i = cyc - t0 - 1;
         if (i < NV) begin
            if (cur.kind == ON) hit = (st[i] == FREE);
            else hit = (st[i] == HELD && chs[i] == cur.ch && keys[i] == cur.key);
            if (hit) begin
               e_addr = i; e_note = cur.key; e_vel = cur.vel; e_ch = cur.ch;
               if (cur.kind == ON) begin e_pr = 1; wr = 1; wi = i; wst = HELD; end
               else if (cur.kind == OFF) begin e_rl = 1; wr = 1; wi = i; wst = REL; end
               else e_kp = 1;
               scanning = 0; busy_until = cyc + 1;
            end else if (i == NV - 1 && !(STEAL && cur.kind == ON)) begin
               scanning = 0; busy_until = cyc;
            end
         end else begin
            e_pr = 1; e_addr = steal; e_note = cur.key; e_vel = cur.vel; e_ch = cur.ch;
            wr = 1; wi = steal; wst = HELD; steal = (steal + 1) % NV;
            scanning = 0; busy_until = cyc + 1;
         end
      end
      if (idle) begin
         if (pend_v) begin
            start_msg(pend);
            pend_v = got; pend = m;
         end else if (got) begin
            start_msg(m);
         end
      end else if (got) begin
         if (pend_v) e_ovf = 1;
         else begin pend_v = 1; pend = m; end
      end
      if (fv && fa < NV) st[fa] = FREE;
      if (wr) begin st[wi] = wst; chs[wi] = cur.ch; keys[wi] = cur.key; end
   endtask

   task automatic tick(input bit r, input int b, input bit bv, input int fa, input bit fv);
      logic [30:0] act, expv;
      ev_t e;
      @(negedge clk96);
      rst = r; midi_byte = 8'(b); midi_byte_valid = bv;
      voice_free_addr = 8'(fa); voice_free_valid = fv;
      model_step(r, b, bv, fa, fv);
      @(posedge clk96);
      #1;
      cyc++;
      act  = {note_pressed, note_released, note_keypress, pitch_wheel, note, velocity, channel, addr, overflow};
      expv = {e_pr, e_rl, e_kp, e_pw, 7'(e_note), 7'(e_vel), 4'(e_ch), 8'(e_addr), e_ovf};
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL cycle %0d outputs {pr,rl,kp,pw,note,vel,ch,addr,ovf}: got %h required %h", cyc, act, expv);
      end
      if (note_pressed || note_released || note_keypress || pitch_wheel) begin
         e.cyc = cyc; e.addr = addr; e.note = note; e.vel = velocity; e.ch = channel;
         e.kind = note_pressed ? EV_PRESS : note_released ? EV_REL : note_keypress ? EV_KP : EV_PW;
         log_q.push_back(e);
      end
   endtask

   task automatic send(input int b);
      tick(1'b0, b, 1'b1, 0, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 0, 1'b0, 0, 1'b0);
   endtask

   task automatic expect_ev(input string name, input int idx, input int kind, input int ecyc,
                            input int eaddr, input int enote, input int ech);
      ev_t e;
      e = '{cyc: -1, kind: -1, addr: -1, note: -1, vel: -1, ch: -1};
      if (idx < log_q.size()) e = log_q[idx];
      chk({name, "_kind"}, e.kind, kind);
      chk({name, "_cycle"}, e.cyc, ecyc);
      chk({name, "_addr"}, e.addr, eaddr);
      chk({name, "_note"}, e.note, enote);
      chk({name, "_chan"}, e.ch, ech);
   endtask

   initial begin
      int t, last_addr, b, fa, sel;
      bit bv, fv, r;
      repeat (3) tick(1'b1, 0, 1'b0, 0, 1'b0);
      chk("reset_pulses", int'({note_pressed, note_released, note_keypress, pitch_wheel}), 0);
      chk("reset_fields", int'({note, velocity, channel, addr, overflow}), 0);
      idle(2);

      log_q.delete(); t = cyc + 2;
      send('h90); send('h3C); send('h64); idle(4);
      chk("noteon_count", log_q.size(), 1);
      expect_ev("noteon", 0, EV_PRESS, t + 2, 0, 'h3C, 0);
      chk("noteon_vel", (log_q.size() > 0) ? log_q[0].vel : -1, 'h64);

      log_q.delete(); t = cyc + 1;
      send('h3C); send('h00); idle(4);
      expect_ev("running_off", 0, EV_REL, t + 2, 0, 'h3C, 0);

      log_q.delete();
      send('h80); send('h3C); send('h40); idle(NV + 4);
      chk("off_miss_pulses", log_q.size(), 0);

      tick(1'b0, 0, 1'b0, 0, 1'b1);
      log_q.delete(); t = cyc + 2;
      send('h91); send('h40); send('h50); send('hF8); send('h41); send('h50); idle(NV + 6);
      chk("two_on_count", log_q.size(), 2);
      expect_ev("two_on_a", 0, EV_PRESS, t + 2, 0, 'h40, 1);
      expect_ev("two_on_b", 1, EV_PRESS, t + 6, 1, 'h41, 1);

      log_q.delete(); t = cyc + 2;
      send('hE2); send('h00); send('h10); idle(3);
      expect_ev("bend", 0, EV_PW, t + 1, 1, 'h10, 2);

      tick(1'b1, 0, 1'b0, 0, 1'b0); idle(1);
      log_q.delete();
      for (int k = 0; k <= NV; k++) begin
         send('h90); send('h20 + k); send('h40); idle(NV + 4);
      end
      chk("exhaust_count", log_q.size(), STEAL ? NV + 1 : NV);
      last_addr = (log_q.size() > 0) ? log_q[log_q.size() - 1].addr : -1;
      chk("exhaust_last_addr", last_addr, STEAL ? 0 : NV - 1);
      tick(1'b0, 0, 1'b0, 3, 1'b1);
      log_q.delete(); t = cyc + 2;
      send('h90); send('h2F); send('h40); idle(NV + 4);
      expect_ev("refill", 0, EV_PRESS, t + 5, 3, 'h2F, 0);

      tick(1'b1, 0, 1'b0, 0, 1'b0); idle(1);
      send('h90); send('h30); send('h40); idle(4);
      send('h31); send('h40); idle(5);
      chk("ovf_before", int'(overflow), 0);
      log_q.delete(); t = cyc + 2;
      send('h80); send('h33); send('h40); send('h30); send('h40); send('h31); send('h40);
      idle(3 * NV + 6);
      chk("ovf_after", int'(overflow), 1);
      chk("ovf_pulses", log_q.size(), 1);
      expect_ev("ovf_pending", 0, EV_REL, t + 7, 0, 'h30, 0);

      // Random traffic, checked every cycle against the model.
      for (int n = 0; n < 4000; n++) begin
         r = ($urandom_range(0, 799) == 0);
         bv = ($urandom_range(0, 99) < 55);
         sel = $urandom_range(0, 19);
         if (sel < 13) b = ($urandom_range(0, 3) == 0) ? 0 : 'h3C + $urandom_range(0, 3);
         else if (sel < 19) begin
            case ($urandom_range(0, 7))
               0: b = 'h80; 1, 2: b = 'h90; 3: b = 'hA0; 4: b = 'hE0; 5: b = 'hB0; 6: b = 'hC0;
               default: b = 'hD0;
            endcase
            b = b + $urandom_range(0, 1);
         end else b = ($urandom_range(0, 1) != 0) ? 'hF8 : 'hF0;
         fv = ($urandom_range(0, 9) == 0);
         fa = $urandom_range(0, NV + 1);
         tick(r, b, bv, fa, fv);
      end
      idle(2 * NV + 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
